mac_seq_ctrl: RTL and testbench

Sequencing controller for the 4-lane MAC tile (four x·w products summed with an incoming partial sum). It accepts a dot-product job of N groups, streams N groups of four activation/weight pairs into the tile at one group per cycle, and feeds the tile's output back as the next psum. It returns the final accumulated sum on a valid/ready result port. It sits between the activation/weight fetch logic and the tile, and owns the tile's inputs and the accumulator register.

---
 rtl/mac_seq_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl -- sequencing controller for the 4-lane MAC tile.
//
// Accepts a dot-product job of `len` groups. Streams one group of four
// activation/weight pairs per cycle into the tile, and feeds the tile
// result back as the next partial sum. The final sum is returned on a
// valid/ready result port.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   start, len, abort       job control (start/len sampled in IDLE only)
//   busy                    high while a job is running or its result is pending
//   in_valid/in_ready       group beat handshake, lanes in_x / in_w
//   mac_x, mac_w, mac_psum  registered tile drive; mac_psum is the accumulator
//   mac_out                 tile result (combinational from the tile drive)
//   out_valid/out_ready     result handshake, out_data = accumulated sum

// Per-lane operand register. It loads on an accepted beat and otherwise
// returns to zero. A zeroed lane contributes nothing, so the tile passes
// psum through unchanged during bubbles.
module mac_seq_lane #(
   parameter int bw = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          load,
   input  logic [bw-1:0] x,
   input  logic [bw-1:0] w,
   output logic [bw-1:0] tile_x,
   output logic [bw-1:0] tile_w
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tile_x <= '0;
         tile_w <= '0;
      end else if (load) begin
         tile_x <= x;
         tile_w <= w;
      end else begin
         tile_x <= '0;
         tile_w <= '0;
      end
   end

endmodule

module mac_seq_ctrl #(
   parameter int bw      = 4,
   parameter int psum_bw = 16,
   parameter int len_bw  = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [len_bw-1:0]   len,
   input  logic                abort,
   output logic                busy,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [4*bw-1:0]     in_x,
   input  logic [4*bw-1:0]     in_w,
   output logic [4*bw-1:0]     mac_x,
   output logic [4*bw-1:0]     mac_w,
   output logic [psum_bw-1:0]  mac_psum,
   input  logic [psum_bw-1:0]  mac_out,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [psum_bw-1:0]  out_data
);

   localparam int LANES = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   logic [psum_bw-1:0]  acc;
   logic [len_bw:0]     issued;
   logic [len_bw:0]     retired;
   logic [len_bw:0]     retired_inc;
   logic [len_bw-1:0]   len_q;
   logic                tile_vld;
   logic                beat;
   logic                load;
   logic                last_retire;

   // Lane views of the flat buses; lane k sits at [k*bw +: bw].
   logic [LANES-1:0][bw-1:0] x_lanes, w_lanes, tx_lanes, tw_lanes;

   assign x_lanes = in_x;
   assign w_lanes = in_w;
   assign mac_x   = tx_lanes;
   assign mac_w   = tw_lanes;

   // in_ready is combinational, so it drops in the same cycle that the
   // last group has been issued.
   assign in_ready    = (state == RUN) && (issued < {1'b0, len_q});
   assign beat        = in_valid & in_ready;
   // abort wins over a coincident beat: the operand registers must clear.
   assign load        = beat & ~abort;
   assign retired_inc = retired + (len_bw+1)'(1);
   assign last_retire = (retired_inc == {1'b0, len_q});

   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);
   assign out_data  = (state == DONE) ? acc : '0;
   // The tile sees the accumulator directly. A beat loaded on the same edge
   // as an acc update therefore always combines with the fresh sum.
   assign mac_psum  = acc;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      mac_seq_lane #(.bw(bw)) u_lane (
         .clk    (clk),
         .reset_n(reset_n),
         .load   (load),
         .x      (x_lanes[k]),
         .w      (w_lanes[k]),
         .tile_x (tx_lanes[k]),
         .tile_w (tw_lanes[k])
      );
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         acc      <= '0;
         issued   <= '0;
         retired  <= '0;
         len_q    <= '0;
         tile_vld <= 1'b0;
      end else if (abort) begin
         // Drop the job and any pending result.
         state    <= IDLE;
         acc      <= '0;
         issued   <= '0;
         retired  <= '0;
         len_q    <= '0;
         tile_vld <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               tile_vld <= 1'b0;
               if (start) begin
                  acc     <= '0;
                  issued  <= '0;
                  retired <= '0;
                  len_q   <= len;
                  // An empty job goes straight to the result with a zero sum.
                  state   <= (len != '0) ? RUN : DONE;
               end
            end
            RUN: begin
               tile_vld <= beat;
               if (beat)
                  issued <= issued + (len_bw+1)'(1);
               // A group sat in the tile for the past cycle: retire it.
               if (tile_vld) begin
                  acc     <= mac_out;
                  retired <= retired_inc;
                  if (last_retire)
                     state <= DONE;
               end
            end
            DONE: begin
               tile_vld <= 1'b0;
               if (out_ready)
                  state <= IDLE;
            end
            default: begin
               state    <= IDLE;
               tile_vld <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl. The tile is modelled as
// mac_out = sum(x_k*w_k) + mac_psum (mod 2^16). A job-level model tracks
// phase, accepted groups and the running dot product. Every cycle the DUT
// outputs are compared against it, and literal results pin the model.
module tb_mac_seq_ctrl;
   localparam int BW = 4;
   localparam int PW = 16;
   localparam int LW = 8;
   localparam int P_IDLE = 0;
   localparam int P_RUN  = 1;
   localparam int P_DONE = 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          start = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [LW-1:0] len = '0;
   logic [4*BW-1:0] in_x = '0, in_w = '0;
   logic          busy, in_ready, out_valid;
   logic [4*BW-1:0] mac_x, mac_w;
   logic [PW-1:0] mac_psum, mac_out, out_data;

   int errs = 0;
   int checks = 0;
   int rdy_cnt = 0;

   // job-level model
   int ph = P_IDLE;
   int m_len = 0, m_iss = 0, m_sum = 0;
   bit fin = 1'b0;
   logic [4*BW-1:0] m_mx = '0, m_mw = '0;

   logic [4*BW-1:0] qx[$];
   logic [4*BW-1:0] qw[$];

   always #5 clk = ~clk;

   mac_seq_ctrl #(.bw(BW), .psum_bw(PW), .len_bw(LW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .len(len), .abort(abort),
      .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_w(in_w), .mac_x(mac_x), .mac_w(mac_w),
      .mac_psum(mac_psum), .mac_out(mac_out), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data)
   );

   function automatic int dot(input logic [4*BW-1:0] x, input logic [4*BW-1:0] w);
      int s = 0;
      for (int k = 0; k < 4; k++) s += int'(x[k*BW +: BW]) * int'(w[k*BW +: BW]);
      return s;
   endfunction

   always_comb mac_out = PW'((dot(mac_x, mac_w) + int'(mac_psum)) & 32'hFFFF);

   function automatic logic [4*BW-1:0] pk(input int a, input int b, input int c, input int d);
      return {BW'(d), BW'(c), BW'(b), BW'(a)};
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      ph = P_IDLE; m_len = 0; m_iss = 0; m_sum = 0; fin = 1'b0;
      m_mx = '0; m_mw = '0;
   endtask

   // Called just after a falling edge with inputs applied. Checks outputs,
   // advances the model across the next rising edge and returns at the
   // following falling edge. `acc` reports a beat accepted on that edge.
   task automatic tick(output bit acc);
      bit b;
      #2;
      chk("busy", int'(busy), int'(ph != P_IDLE));
      chk("in_ready", int'(in_ready), int'(ph == P_RUN && m_iss < m_len));
      chk("out_valid", int'(out_valid), int'(ph == P_DONE));
      chk("mac_x", int'(mac_x), int'(m_mx));
      chk("mac_w", int'(mac_w), int'(m_mw));
      if (ph == P_DONE) chk("out_data", int'(out_data), m_sum);
      if (in_ready) rdy_cnt++;
      b = in_valid && ph == P_RUN && m_iss < m_len && !abort;
      acc = b;
      m_mx = b ? in_x : '0;
      m_mw = b ? in_w : '0;
      if (abort) begin
         ph = P_IDLE; m_len = 0; m_iss = 0; m_sum = 0; fin = 1'b0;
      end else begin
         case (ph)
            P_IDLE: if (start) begin
               m_sum = 0; m_iss = 0; fin = 1'b0; m_len = int'(len);
               ph = (len != 0) ? P_RUN : P_DONE;
            end
            P_RUN: begin
               if (fin) begin
                  ph = P_DONE; fin = 1'b0;
               end else if (b) begin
                  m_sum = (m_sum + dot(in_x, in_w)) & 32'hFFFF;
                  m_iss++;
                  if (m_iss == m_len) fin = 1'b1;
               end
            end
            default: if (out_ready) ph = P_IDLE;
         endcase
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input string nm);
      #3 reset_n = 1'b0;
      #1;
      chk({nm, " busy"}, int'(busy), 0);
      chk({nm, " in_ready"}, int'(in_ready), 0);
      chk({nm, " out_valid"}, int'(out_valid), 0);
      chk({nm, " out_data"}, int'(out_data), 0);
      chk({nm, " mac_x"}, int'(mac_x), 0);
      chk({nm, " mac_w"}, int'(mac_w), 0);
      chk({nm, " mac_psum"}, int'(mac_psum), 0);
      model_clear();
      @(negedge clk);
      start = 0; abort = 0; in_valid = 0; out_ready = 0; in_x = '0; in_w = '0;
      reset_n = 1'b1;
   endtask

   // Runs a job over qx/qw. bub = idle cycles after each beat, hold = cycles
   // with out_ready low (start high) once the result is up, lat = expected
   // extra cycles from the last beat tick to out_valid (-1 skips).
   task automatic job(input string nm, input int n, input int bub, input int hold,
                      input int lat, input int exp_sum);
      bit b;
      int i = 0, g = 0;
      start = 1; len = LW'(n);
      tick(b);
      start = 0; len = '0;
      while (i < n && g < 1000) begin
         in_valid = 1; in_x = qx[i]; in_w = qw[i];
         tick(b);
         g++;
         if (b) begin
            i++;
            if (bub > 0) begin
               in_valid = 0; in_x = '0; in_w = '0;
               repeat (bub) tick(b);
            end
         end
      end
      in_valid = 0; in_x = '0; in_w = '0;
      chk({nm, " beats"}, i, n);
      g = 0;
      while (!out_valid && g < 50) begin
         tick(b);
         g++;
      end
      chk({nm, " out_valid"}, int'(out_valid), 1);
      if (lat >= 0) chk({nm, " latency"}, g, lat);
      chk({nm, " sum"}, int'(out_data), exp_sum);
      start = (hold > 0);
      repeat (hold) tick(b);
      start = 0;
      if (hold > 0) begin
         chk({nm, " held"}, int'(out_data), exp_sum);
         chk({nm, " held in_ready"}, int'(in_ready), 0);
      end
      out_ready = 1;
      tick(b);
      out_ready = 0;
      chk({nm, " idle"}, int'(busy), 0);
   endtask

   task automatic load3();
      qx = {}; qw = {};
      qx.push_back(pk(1, 2, 3, 4));     qw.push_back(pk(1, 1, 1, 1));
      qx.push_back(pk(2, 2, 2, 2));     qw.push_back(pk(3, 3, 3, 3));
      qx.push_back(pk(15, 15, 15, 15)); qw.push_back(pk(1, 1, 1, 1));
   endtask

   initial begin
      bit b;
      #1 reset_n = 1'b0;
      #1;
      chk("reset busy", int'(busy), 0);
      chk("reset out_valid", int'(out_valid), 0);
      chk("reset mac_psum", int'(mac_psum), 0);
      @(negedge clk);
      reset_n = 1'b1;
      model_clear();
      tick(b);

      // single group
      qx = {pk(1, 2, 3, 4)}; qw = {pk(1, 1, 1, 1)};
      job("len1", 1, 0, 0, 1, 10);

      // three groups back-to-back
      load3();
      rdy_cnt = 0;
      job("len3", 3, 0, 0, 1, 94);
      chk("len3 ready cycles", rdy_cnt, 3);

      // bubbles and a stalled consumer
      load3();
      job("len3 bubbly", 3, 2, 5, -1, 94);

      // empty job
      job("len0", 0, 0, 2, 0, 0);

      // wrap-around
      qx = {}; qw = {};
      for (int i = 0; i < 73; i++) begin
         qx.push_back(pk(15, 15, 15, 15));
         qw.push_back(pk(15, 15, 15, 15));
      end
      job("len73", 73, 0, 0, 1, 164);

      // abort after two beats of a four-beat job
      start = 1; len = 8'd4; tick(b); start = 0;
      in_valid = 1; in_x = pk(3, 3, 3, 3); in_w = pk(2, 2, 2, 2);
      tick(b); tick(b);
      in_valid = 0; abort = 1; tick(b); abort = 0;
      chk("abort busy", int'(busy), 0);
      chk("abort in_ready", int'(in_ready), 0);
      tick(b); tick(b);
      qx = {pk(1, 2, 3, 4)}; qw = {pk(1, 1, 1, 1)};
      job("after abort", 1, 0, 0, 1, 10);

      // reset mid-RUN
      start = 1; len = 8'd3; tick(b); start = 0;
      in_valid = 1; in_x = pk(5, 5, 5, 5); in_w = pk(5, 5, 5, 5);
      tick(b);
      do_reset("rst run");
      tick(b);
      qx = {pk(1, 2, 3, 4)}; qw = {pk(1, 1, 1, 1)};
      job("after rst run", 1, 0, 0, 1, 10);

      // reset mid-DONE
      start = 1; len = 8'd1; tick(b); start = 0;
      in_valid = 1; in_x = pk(7, 7, 7, 7); in_w = pk(1, 1, 1, 1);
      tick(b); in_valid = 0;
      tick(b); tick(b);
      chk("pre rst done out_valid", int'(out_valid), 1);
      do_reset("rst done");
      tick(b);
      load3();
      job("after rst done", 3, 1, 1, -1, 94);

      // random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         start     = ($urandom_range(0, 5) == 0);
         len       = LW'($urandom_range(0, 9));
         in_valid  = ($urandom_range(0, 2) != 0);
         in_x      = 16'($urandom);
         in_w      = 16'($urandom);
         out_ready = ($urandom_range(0, 3) == 0);
         abort     = ($urandom_range(0, 80) == 0);
         tick(b);
      end
      start = 0; in_valid = 0; abort = 0; out_ready = 0;
      tick(b);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
